// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, applies EX/ID redirects, halt and hazard stalls.
// Latency: inst at imem_addr_o appears on id_inst_o one edge later; stall_i holds IF/ID, pc_write_i holds PC.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_inst_i,
   input  logic             pc_write_i,
   input  logic             stall_i,
   input  logic             id_redirect_i,
   input  logic [31:0]      id_target_i,
   input  logic             ex_mispredict_i,
   input  logic [31:0]      ex_correct_pc_i,
   input  logic             halt_i,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_pc_plus4_o,
   output logic [31:0]      id_inst_o,
   output logic             id_valid_o,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] inst;
      logic        valid;
   } ifid_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   ifid_t             ifid_q, ifid_d, ifid_bubble;
   logic              fetch_inc, flush_inc;
   logic [CNT_W-1:0]  fetch_cnt_q, flush_cnt_q;
   logic [31:0]       pc_plus4;
   logic [31:0]       ex_pc_aligned, id_pc_aligned;

   assign pc_plus4      = pc_q + 32'd4;
   assign ex_pc_aligned = ex_correct_pc_i & ~32'h3;
   assign id_pc_aligned = id_target_i & ~32'h3;

   // A bubble keeps the PC fields of the squashed slot; only inst/valid change.
   always_comb begin
      ifid_bubble       = ifid_q;
      ifid_bubble.inst  = NOP_INST;
      ifid_bubble.valid = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         ifid_q      <= '{pc: 32'h0, pc_plus4: 32'h0, inst: NOP_INST, valid: 1'b0};
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         if (fetch_inc && (fetch_cnt_q != '1))
            fetch_cnt_q <= fetch_cnt_q + 1'b1;
         if (flush_inc && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN: begin
            if (ex_mispredict_i)                  state_d = RUN;
            else if (id_redirect_i && !stall_i)   state_d = RUN;
            else if (halt_i)                      state_d = HALT;
         end
         HALT:    if (ex_mispredict_i) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      pc_d      = pc_q;
      ifid_d    = ifid_q;
      fetch_inc = 1'b0;
      flush_inc = 1'b0;
      case (state_q)
         RUN: begin
            if (ex_mispredict_i) begin
               pc_d      = ex_pc_aligned;
               ifid_d    = ifid_bubble;
               flush_inc = 1'b1;
            end else if (id_redirect_i && !stall_i) begin
               pc_d      = id_pc_aligned;
               ifid_d    = ifid_bubble;
               flush_inc = 1'b1;
            end else if (halt_i) begin
               ifid_d    = ifid_bubble;
            end else begin
               if (pc_write_i)
                  pc_d = pc_plus4;
               if (!stall_i) begin
                  ifid_d    = '{pc: pc_q, pc_plus4: pc_plus4, inst: imem_inst_i, valid: 1'b1};
                  fetch_inc = 1'b1;
               end
            end
         end
         HALT: begin
            if (ex_mispredict_i) begin
               pc_d      = ex_pc_aligned;
               ifid_d    = ifid_bubble;
               flush_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign imem_addr_o   = pc_q;
   assign id_pc_o       = ifid_q.pc;
   assign id_pc_plus4_o = ifid_q.pc_plus4;
   assign id_inst_o     = ifid_q.inst;
   assign id_valid_o    = ifid_q.valid;
   assign fetch_cnt_o   = fetch_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: expected IF/ID + PC + counter snapshots are queued as stimulus is driven.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] id_pc;
      logic [31:0] id_pc4;
      logic [31:0] inst;
      logic        valid;
      logic [31:0] fetch;
      logic [31:0] flush;
   } snap_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] imem_addr_o, imem_inst_i;
   logic        pc_write_i, stall_i, id_redirect_i, ex_mispredict_i, halt_i;
   logic [31:0] id_target_i, ex_correct_pc_i;
   logic [31:0] id_pc_o, id_pc_plus4_o, id_inst_o;
   logic        id_valid_o;
   logic [31:0] fetch_cnt_o, flush_cnt_o;

   int    checks = 0;
   int    errors = 0;
   snap_t sb[$];
   snap_t e, want, got;

   always #5 clk_i = ~clk_i;
   assign imem_inst_i = imem_addr_o ^ KEY;

   fetch_unit dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
      .pc_write_i(pc_write_i), .stall_i(stall_i),
      .id_redirect_i(id_redirect_i), .id_target_i(id_target_i),
      .ex_mispredict_i(ex_mispredict_i), .ex_correct_pc_i(ex_correct_pc_i),
      .halt_i(halt_i),
      .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o), .id_inst_o(id_inst_o),
      .id_valid_o(id_valid_o), .fetch_cnt_o(fetch_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   function automatic snap_t sample();
      return '{pc: imem_addr_o, id_pc: id_pc_o, id_pc4: id_pc_plus4_o, inst: id_inst_o,
               valid: id_valid_o, fetch: fetch_cnt_o, flush: flush_cnt_o};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      pc_write_i = 1'b1; stall_i = 1'b0; id_redirect_i = 1'b0; ex_mispredict_i = 1'b0;
      halt_i = 1'b0; id_target_i = 32'h0; ex_correct_pc_i = 32'h0;
   endtask

   task automatic model_reset();
      e = '{pc: 32'h0, id_pc: 32'h0, id_pc4: 32'h0, inst: NOP, valid: 1'b0, fetch: 32'h0, flush: 32'h0};
   endtask

   task automatic model_fetch();
      e.id_pc = e.pc; e.id_pc4 = e.pc + 32'd4; e.inst = e.pc ^ KEY; e.valid = 1'b1;
      e.fetch = e.fetch + 1; e.pc = e.pc + 32'd4;
   endtask

   task automatic model_flush(input logic [31:0] tgt);
      e.pc = {tgt[31:2], 2'b00}; e.inst = NOP; e.valid = 1'b0; e.flush = e.flush + 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1'b0;
      model_reset();
      sb.push_back(e);
      #12;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_state got=%h want=%h", got, want); end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      sb.push_back(e);                 // BOOT edge: nothing moves
      model_fetch(); sb.push_back(e);
      model_fetch(); sb.push_back(e);
      for (int i = 0; i < 3; i++) begin
         tick();
         got = sample(); want = sb.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL boot_fetch[%0d] got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin   // advance PC 0x8 -> 0x10
         model_fetch(); sb.push_back(e); tick();
         got = sample(); want = sb.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL pre_stall[%0d] got=%h want=%h", i, got, want); end
      end
      pc_write_i = 1'b0; stall_i = 1'b1;
      sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL stall_hold got=%h want=%h", got, want); end
      idle_inputs();
      model_fetch(); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL stall_release got=%h want=%h", got, want); end
   endtask

   task automatic test_redirect();
      model_fetch(); sb.push_back(e); tick();   // PC now 0x18
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pre_redirect got=%h want=%h", got, want); end
      id_redirect_i = 1'b1; id_target_i = 32'h40;
      model_flush(32'h40); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL redirect got=%h want=%h", got, want); end
      id_target_i = 32'h80; stall_i = 1'b1; pc_write_i = 1'b0;
      sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL redirect_stalled got=%h want=%h", got, want); end
      idle_inputs();
      model_fetch(); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL post_redirect got=%h want=%h", got, want); end
   endtask

   task automatic test_mispredict();
      ex_mispredict_i = 1'b1; ex_correct_pc_i = 32'h1C;
      id_redirect_i = 1'b1; id_target_i = 32'h80; halt_i = 1'b1; pc_write_i = 1'b0;
      model_flush(32'h1C); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mispredict_priority got=%h want=%h", got, want); end
      idle_inputs();
      ex_mispredict_i = 1'b1; ex_correct_pc_i = 32'h23;
      model_flush(32'h23); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mispredict_align got=%h want=%h", got, want); end
      idle_inputs();
      model_fetch(); sb.push_back(e); tick();   // PC now 0x24
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL post_mispredict got=%h want=%h", got, want); end
   endtask

   task automatic test_halt();
      halt_i = 1'b1;
      e.inst = NOP; e.valid = 1'b0; sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL halt_enter got=%h want=%h", got, want); end
      for (int i = 0; i < 10; i++) begin
         halt_i = 1'(i & 1); id_redirect_i = 1'b1; id_target_i = 32'h80;
         stall_i = 1'(i >> 1); pc_write_i = 1'b1;
         sb.push_back(e); tick();
         got = sample(); want = sb.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL halt_hold[%0d] got=%h want=%h", i, got, want); end
      end
      idle_inputs();
      ex_mispredict_i = 1'b1; ex_correct_pc_i = 32'h30;
      model_flush(32'h30); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL halt_exit got=%h want=%h", got, want); end
      idle_inputs();
      model_fetch(); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL halt_resume got=%h want=%h", got, want); end
   endtask

   task automatic test_wrap();
      ex_mispredict_i = 1'b1; ex_correct_pc_i = 32'hFFFF_FFFF;
      model_flush(32'hFFFF_FFFF); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL wrap_load got=%h want=%h", got, want); end
      idle_inputs();
      model_fetch(); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL wrap_advance got=%h want=%h", got, want); end
   endtask

   task automatic test_async_reset();
      model_fetch(); sb.push_back(e); tick();
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pre_async got=%h want=%h", got, want); end
      #2 rst_i = 1'b0;
      model_reset(); sb.push_back(e);
      #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL async_reset got=%h want=%h", got, want); end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      sb.push_back(e);
      model_fetch(); sb.push_back(e);
      for (int i = 0; i < 2; i++) begin
         tick();
         got = sample(); want = sb.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL reboot[%0d] got=%h want=%h", i, got, want); end
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_mispredict();
      test_halt();
      test_wrap();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d want=0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout reached=20000ns want=finish");
      $fatal(1);
   end

endmodule
